// File: rtl/tl_source_tracker.sv
// Passive per-source TileLink A/D transaction tracker.
// Records each fired A request by source ID, checks every fired D beat against the
// recorded entry, and flags duplicate sources, orphan responses, opcode/size mismatches,
// illegal A opcodes and timeouts. All outputs are registered (one cycle after the fire edge).
module tl_source_tracker #(
   parameter int SOURCE_BITS = 4,
   parameter int SIZE_BITS   = 3,
   parameter int BEAT_BYTES  = 8,
   parameter int TIMEOUT     = 1023
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   a_valid,
   input  logic                   a_ready,
   input  logic [2:0]             a_opcode,
   input  logic [SIZE_BITS-1:0]   a_size,
   input  logic [SOURCE_BITS-1:0] a_source,
   input  logic                   d_valid,
   input  logic                   d_ready,
   input  logic [2:0]             d_opcode,
   input  logic [SIZE_BITS-1:0]   d_size,
   input  logic [SOURCE_BITS-1:0] d_source,
   output logic                   err_valid,
   output logic [2:0]             err_code,
   output logic [SOURCE_BITS-1:0] err_source,
   output logic [SOURCE_BITS:0]   inflight,
   output logic [7:0]             err_count
);

   localparam int NSRC   = 2**SOURCE_BITS;
   localparam int LOG_BB = $clog2(BEAT_BYTES);
   localparam int BEAT_W = 2**SIZE_BITS + 1;
   localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   localparam logic [2:0] E_NONE     = 3'd0;
   localparam logic [2:0] E_DUP_SRC  = 3'd1;
   localparam logic [2:0] E_ORPHAN_D = 3'd2;
   localparam logic [2:0] E_BAD_OPC  = 3'd3;
   localparam logic [2:0] E_BAD_SIZE = 3'd4;
   localparam logic [2:0] E_TIMEOUT  = 3'd5;
   localparam logic [2:0] E_ILLEGAL  = 3'd6;

   // Expected D opcode for a given A opcode (6/7 never reach the table).
   function automatic logic [2:0] exp_opc_f(input logic [2:0] opc);
      case (opc)
         3'd0, 3'd1:       return 3'd0;
         3'd2, 3'd3, 3'd4: return 3'd1;
         default:          return 3'd2;
      endcase
   endfunction

   // Number of D beats: data responses span the transfer size in BEAT_BYTES beats, min 1.
   function automatic logic [BEAT_W-1:0] beats_f(input logic [2:0] eopc,
                                                 input logic [SIZE_BITS-1:0] sz);
      logic [BEAT_W-1:0] b;
      b = BEAT_W'(1);
      if (eopc == 3'd1 && int'(sz) > LOG_BB) b = BEAT_W'(1) << (int'(sz) - LOG_BB);
      return b;
   endfunction

   logic                  pending_q [NSRC];
   logic                  pending_d [NSRC];
   logic [2:0]            exp_opc_q [NSRC];
   logic [2:0]            exp_opc_d [NSRC];
   logic [SIZE_BITS-1:0]  size_q    [NSRC];
   logic [SIZE_BITS-1:0]  size_d    [NSRC];
   logic [BEAT_W-1:0]     beats_q   [NSRC];
   logic [BEAT_W-1:0]     beats_d   [NSRC];
   logic [15:0]           age_q     [NSRC];
   logic [15:0]           age_d     [NSRC];

   logic                   err_valid_q, err_valid_d;
   logic [2:0]             err_code_q, err_code_d;
   logic [SOURCE_BITS-1:0] err_source_q, err_source_d;
   logic [SOURCE_BITS:0]   inflight_q, inflight_d;
   logic [7:0]             err_count_q, err_count_d;

   logic                   a_fire, d_fire, d_retire, to_hit;
   logic [2:0]             d_code, a_code;
   logic [SOURCE_BITS-1:0] to_src;
   logic [1:0]             n_err;
   logic [8:0]             count_sum;

   // Table update and error selection: D is applied before A so a retiring beat frees the slot.
   always_comb begin
      a_fire   = a_valid & a_ready;
      d_fire   = d_valid & d_ready;
      d_code   = E_NONE;
      a_code   = E_NONE;
      d_retire = 1'b0;
      to_hit   = 1'b0;
      to_src   = '0;
      for (int i = 0; i < NSRC; i++) begin
         pending_d[i] = pending_q[i];
         exp_opc_d[i] = exp_opc_q[i];
         size_d[i]    = size_q[i];
         beats_d[i]   = beats_q[i];
         age_d[i]     = age_q[i];
      end

      if (d_fire) begin
         if (!pending_q[d_source]) begin
            d_code = E_ORPHAN_D;
         end else begin
            if (d_opcode != exp_opc_q[d_source])  d_code = E_BAD_OPC;
            else if (d_size != size_q[d_source])  d_code = E_BAD_SIZE;
            if (beats_q[d_source] == BEAT_W'(1)) begin
               pending_d[d_source] = 1'b0;
               d_retire            = 1'b1;
            end else begin
               beats_d[d_source] = beats_q[d_source] - BEAT_W'(1);
            end
         end
      end

      // Ageing; the timeout fires once, on the transition into the saturated value.
      for (int i = 0; i < NSRC; i++) begin
         if (pending_q[i] && age_q[i] != TO_MAX) age_d[i] = age_q[i] + 16'd1;
         if (pending_q[i] && age_q[i] == TO_LAST && !to_hit &&
             !(d_retire && d_source == SOURCE_BITS'(i))) begin
            to_hit = 1'b1;
            to_src = SOURCE_BITS'(i);
         end
      end

      if (a_fire) begin
         if (a_opcode[2:1] == 2'b11) begin
            a_code = E_ILLEGAL;
         end else if (pending_d[a_source]) begin
            a_code = E_DUP_SRC;
         end else begin
            pending_d[a_source] = 1'b1;
            exp_opc_d[a_source] = exp_opc_f(a_opcode);
            size_d[a_source]    = a_size;
            beats_d[a_source]   = beats_f(exp_opc_f(a_opcode), a_size);
            age_d[a_source]     = 16'd0;
         end
      end

      err_valid_d  = 1'b1;
      err_code_d   = E_NONE;
      err_source_d = '0;
      if (d_code != E_NONE) begin
         err_code_d   = d_code;
         err_source_d = d_source;
      end else if (a_code != E_NONE) begin
         err_code_d   = a_code;
         err_source_d = a_source;
      end else if (to_hit) begin
         err_code_d   = E_TIMEOUT;
         err_source_d = to_src;
      end else begin
         err_valid_d  = 1'b0;
      end

      n_err       = {1'b0, d_code != E_NONE} + {1'b0, a_code != E_NONE} + {1'b0, to_hit};
      count_sum   = {1'b0, err_count_q} + {7'd0, n_err};
      err_count_d = count_sum[8] ? 8'hff : count_sum[7:0];

      inflight_d = '0;
      for (int i = 0; i < NSRC; i++) inflight_d = inflight_d + {{SOURCE_BITS{1'b0}}, pending_d[i]};
   end

   // State and registered outputs; asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSRC; i++) begin
            pending_q[i] <= 1'b0;
            exp_opc_q[i] <= '0;
            size_q[i]    <= '0;
            beats_q[i]   <= '0;
            age_q[i]     <= '0;
         end
         err_valid_q  <= 1'b0;
         err_code_q   <= '0;
         err_source_q <= '0;
         inflight_q   <= '0;
         err_count_q  <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            pending_q[i] <= pending_d[i];
            exp_opc_q[i] <= exp_opc_d[i];
            size_q[i]    <= size_d[i];
            beats_q[i]   <= beats_d[i];
            age_q[i]     <= age_d[i];
         end
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         err_source_q <= err_source_d;
         inflight_q   <= inflight_d;
         err_count_q  <= err_count_d;
      end
   end

   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;
   assign err_source = err_source_q;
   assign inflight   = inflight_q;
   assign err_count  = err_count_q;

endmodule
